// File: rtl/kernel_pkg.sv
// Shared definitions for the Gaussian kernel generator: Q0.16 weight table,
// FSM state encoding and width constants.
package kernel_pkg;

    localparam int SIGMA_W    = 3;
    localparam int DIST_W     = 3;
    localparam int ROM_ADDR_W = SIGMA_W + DIST_W;
    localparam int G_W        = 16;
    // Extra accumulator bits above COEF_W; SIZE*SIZE <= 225 < 2**8.
    localparam int SUM_GROWTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EXPAND,
        ST_DONE
    } state_t;

    // g(sigma, d) = round(65535 * exp(-d^2 / (2 * sigma^2))), rows sigma = 1..7, columns d = 0..7.
    localparam logic [G_W-1:0] G_TABLE [7][8] = '{
        '{16'd65535, 16'd39749, 16'd8869,  16'd728,   16'd22,    16'd0,     16'd0,     16'd0    },
        '{16'd65535, 16'd57834, 16'd39749, 16'd21276, 16'd8869,  16'd2879,  16'd728,   16'd143  },
        '{16'd65535, 16'd61993, 16'd52476, 16'd39749, 16'd26942, 16'd16341, 16'd8869,  16'd4308 },
        '{16'd65535, 16'd63519, 16'd57834, 16'd49468, 16'd39749, 16'd30004, 16'd21276, 16'd14173},
        '{16'd65535, 16'd64237, 16'd60496, 16'd54739, 16'd47588, 16'd39749, 16'd31899, 16'd24596},
        '{16'd65535, 16'd64631, 16'd61993, 16'd57834, 16'd52476, 16'd46310, 16'd39749, 16'd33183},
        '{16'd65535, 16'd64870, 16'd62914, 16'd59785, 16'd55663, 16'd50779, 16'd45388, 16'd39749}
    };

    // Address is {sigma, d}; sigma == 0 has no table row and reads as zero.
    function automatic logic [G_W-1:0] weight_lookup(input logic [ROM_ADDR_W-1:0] addr);
        logic [SIGMA_W-1:0] s;
        logic [DIST_W-1:0]  d;
        s = addr[ROM_ADDR_W-1:DIST_W];
        d = addr[DIST_W-1:0];
        if (s == '0) begin
            return '0;
        end
        return G_TABLE[s - SIGMA_W'(1)][d];
    endfunction

endpackage

// File: rtl/gaussian_kernel_gen_rom.sv
// Synchronous-read Gaussian weight ROM, one cycle from address to data.
module gaussian_weight_rom
    import kernel_pkg::*;
(
    input  logic                  clk,
    input  logic [ROM_ADDR_W-1:0] addr,
    output logic [G_W-1:0]        data
);

    // Registered table read.
    // NOTE: the read register carries no reset; its value is only consumed one cycle after LOAD drives a valid address.
    // NOTE: non-blocking assignment keeps every flop sampling pre-edge values, so ordering between always blocks never matters.
    always_ff @(posedge clk) begin
        data <= weight_lookup(addr);
    end

endmodule

// File: rtl/gaussian_kernel_gen.sv
// Gaussian kernel generator: loads the 1D weight profile for the captured sigma
// from the ROM, then expands it into a SIZE x SIZE kernel (2D outer product)
// or into the centre row only (separable mode), accumulating the kernel sum.
module gaussian_kernel_gen
    import kernel_pkg::*;
#(
    parameter int SIZE   = 7,
    parameter int COEF_W = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [SIGMA_W-1:0]                   sigma,
    input  logic                                 mode,
    input  logic                                 start,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err,
    output logic [SIZE-1:0][SIZE-1:0][COEF_W-1:0] kernel,
    output logic [COEF_W+SUM_GROWTH-1:0]         sum
);

    localparam int HALF   = (SIZE - 1) / 2;
    localparam int IDX_W  = $clog2(SIZE);
    localparam int WIDX_W = (HALF > 0) ? $clog2(HALF + 1) : 1;
    localparam int LD_W   = $clog2(HALF + 2);
    localparam int PROD_W = 2 * COEF_W;
    localparam int SUM_W  = COEF_W + SUM_GROWTH;

    localparam logic [IDX_W-1:0] CENTRE   = IDX_W'(HALF);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SIZE - 1);
    localparam logic [LD_W-1:0]  LD_LAST  = LD_W'(HALF + 1);

    state_t              state;
    state_t              state_next;
    logic [SIGMA_W-1:0]  sigma_q;
    logic                mode_q;
    logic [LD_W-1:0]     ld_cnt;
    logic [IDX_W-1:0]    row;
    logic [IDX_W-1:0]    col;
    logic [COEF_W-1:0]   w [HALF+1];

    logic [ROM_ADDR_W-1:0] rom_addr;
    logic [G_W-1:0]        rom_data;
    logic [WIDX_W-1:0]     w_wr_idx;
    logic [WIDX_W-1:0]     drow;
    logic [WIDX_W-1:0]     dcol;
    logic [PROD_W-1:0]     prod;
    logic [PROD_W-1:0]     prod_rnd;
    logic [COEF_W-1:0]     coef;
    logic                  last_expand;
    logic                  unused_bits;

    // Distance of a row/column index from the kernel centre.
    function automatic logic [WIDX_W-1:0] centre_dist(input logic [IDX_W-1:0] idx);
        if (idx >= CENTRE) begin
            return WIDX_W'(idx - CENTRE);
        end
        return WIDX_W'(CENTRE - idx);
    endfunction

    // LOAD walks d = 0..HALF; the ROM answers one cycle later, so w[] lags the address by one.
    assign rom_addr    = {sigma_q, DIST_W'(ld_cnt)};
    assign w_wr_idx    = WIDX_W'(ld_cnt - LD_W'(1));
    assign drow        = centre_dist(row);
    assign dcol        = centre_dist(col);
    assign last_expand = (col == LAST_IDX) && (mode_q || (row == LAST_IDX));

    // Low ROM bits and the discarded rounding bits are intentionally dropped.
    assign unused_bits = ^{rom_data, prod_rnd[COEF_W-1:0]};

    gaussian_weight_rom u_rom (
        .clk  (clk),
        .addr (rom_addr),
        .data (rom_data)
    );

    // Coefficient for the current raster position: rounded outer product, or the raw weight in separable mode.
    // NOTE: every output of a combinational block is assigned on every path, so no latch can be inferred.
    always_comb begin
        prod     = PROD_W'(w[drow]) * PROD_W'(w[dcol]);
        prod_rnd = prod + (PROD_W'(1) << (COEF_W - 1));
        coef     = mode_q ? w[dcol] : prod_rnd[PROD_W-1:COEF_W];
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // FSM next-state logic; an illegal sigma skips straight to DONE.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (sigma == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_cnt == LD_LAST) begin
                    state_next = ST_EXPAND;
                end
            end
            ST_EXPAND: begin
                if (last_expand) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        busy = (state == ST_LOAD) || (state == ST_EXPAND);
        done = (state == ST_DONE);
    end

    // Request capture, weight loading, kernel expansion and sum accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            sigma_q <= '0;
            mode_q  <= 1'b0;
            err     <= 1'b0;
            ld_cnt  <= '0;
            row     <= '0;
            col     <= '0;
            kernel  <= '0;
            sum     <= '0;
            for (int i = 0; i <= HALF; i++) begin
                w[i] <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sigma_q <= sigma;
                        mode_q  <= mode;
                        if (sigma == '0) begin
                            err <= 1'b1;
                        end else begin
                            err    <= 1'b0;
                            kernel <= '0;
                            sum    <= '0;
                            ld_cnt <= '0;
                            row    <= mode ? CENTRE : '0;
                            col    <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    ld_cnt <= ld_cnt + LD_W'(1);
                    if (ld_cnt != '0) begin
                        w[w_wr_idx] <= rom_data[G_W-1 -: COEF_W];
                    end
                end
                ST_EXPAND: begin
                    kernel[row][col] <= coef;
                    sum              <= sum + SUM_W'(coef);
                    if (col == LAST_IDX) begin
                        col <= '0;
                        row <= row + IDX_W'(1);
                    end else begin
                        col <= col + IDX_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gaussian_kernel_gen.sv
// Scoreboard bench for gaussian_kernel_gen (SIZE=7, COEF_W=8): stimulus pushes
// hand-computed expected results, a monitor pops and compares on every done.
module tb_gaussian_kernel_gen;

    localparam int SIZE   = 7;
    localparam int COEF_W = 8;
    localparam int SUM_W  = COEF_W + 8;

    typedef logic [SIZE-1:0][SIZE-1:0][COEF_W-1:0] kern_t;

    typedef struct {
        kern_t            kernel;
        logic [SUM_W-1:0] sum;
        logic             err;
        int               latency;
        int               start_edge;
    } exp_t;

    logic             clk;
    logic             rst;
    logic [2:0]       sigma;
    logic             mode;
    logic             start;
    logic             busy;
    logic             done;
    logic             err;
    kern_t            kernel;
    logic [SUM_W-1:0] sum;

    int   n_cmp;
    int   n_bad;
    int   edge_cnt;
    exp_t sb[$];

    exp_t e_1d_s2;
    exp_t e_2d_s2;
    exp_t e_err;
    exp_t e_1d_s1;
    exp_t e_1d_s7;

    gaussian_kernel_gen #(
        .SIZE   (SIZE),
        .COEF_W (COEF_W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .sigma  (sigma),
        .mode   (mode),
        .start  (start),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .kernel (kernel),
        .sum    (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial edge_cnt = 0;
    always @(posedge clk) edge_cnt = edge_cnt + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic check_kernel(input string name, input kern_t act, input kern_t req);
        bit found;
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            found = 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) begin
                    if (!found && act[i][j] !== req[i][j]) begin
                        found = 1'b1;
                        $display("FAIL %s: k[%0d][%0d] got %0d, expected %0d", name, i, j, act[i][j], req[i][j]);
                    end
                end
            end
        end
    endtask

    // Separable result: centre row holds the weights c0 (centre) .. c3 (edge), other rows zero.
    function automatic kern_t row_only(input int c0, input int c1, input int c2, input int c3);
        kern_t k;
        int    v [4];
        k = '0;
        v = '{c0, c1, c2, c3};
        for (int j = 0; j < SIZE; j++) begin
            k[3][j] = COEF_W'(v[(j >= 3) ? j - 3 : 3 - j]);
        end
        return k;
    endfunction

    // 2D result for sigma=2, indexed by distance from centre (hand-rounded products of 255,225,155,83).
    function automatic kern_t full_2d_s2();
        kern_t k;
        int    lut [4][4];
        lut = '{'{254, 224, 154, 83}, '{224, 198, 136, 73}, '{154, 136, 94, 50}, '{83, 73, 50, 27}};
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) begin
                k[i][j] = COEF_W'(lut[(i >= 3) ? i - 3 : 3 - i][(j >= 3) ? j - 3 : 3 - j]);
            end
        end
        return k;
    endfunction

    function automatic exp_t make_exp(input kern_t k, input int s, input logic e, input int lat);
        exp_t x;
        x.kernel     = k;
        x.sum        = SUM_W'(s);
        x.err        = e;
        x.latency    = lat;
        x.start_edge = 0;
        return x;
    endfunction

    // Drive a one-cycle start; the expected result (if any) is queued before the DUT can answer.
    task automatic run_req(input logic [2:0] s, input logic m, input exp_t e, input bit push, input logic busy_req);
        @(negedge clk);
        sigma = s;
        mode  = m;
        start = 1'b1;
        e.start_edge = edge_cnt;
        if (push) sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", {63'd0, busy}, {63'd0, busy_req});
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
        check("busy_in_done", {63'd0, busy}, 64'd0);
    endtask

    // Monitor: every done pulse is matched against the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("done_latency", 64'(edge_cnt - e.start_edge), 64'(e.latency));
                check("err", {63'd0, err}, {63'd0, e.err});
                check("sum", 64'(sum), 64'(e.sum));
                check_kernel("kernel", kernel, e.kernel);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        start = 1'b0;
        sigma = 3'd0;
        mode  = 1'b0;

        e_1d_s2 = make_exp(row_only(255, 225, 155, 83), 1181, 1'b0, 13);
        e_2d_s2 = make_exp(full_2d_s2(), 5446, 1'b0, 55);
        e_err   = make_exp(full_2d_s2(), 5446, 1'b1, 1);
        e_1d_s1 = make_exp(row_only(255, 155, 34, 2), 637, 1'b0, 13);
        e_1d_s7 = make_exp(row_only(255, 253, 245, 233), 1717, 1'b0, 13);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_err", {63'd0, err}, 64'd0);
        check("reset_sum", 64'(sum), 64'd0);
        check_kernel("reset_kernel", kernel, '0);

        // Separable, sigma=2.
        run_req(3'd2, 1'b1, e_1d_s2, 1'b1, 1'b1);
        wait_done(100);

        // Full 2D, sigma=2, plus hand spot values.
        run_req(3'd2, 1'b0, e_2d_s2, 1'b1, 1'b1);
        wait_done(200);
        check("k33", 64'(kernel[3][3]), 64'd254);
        check("k00", 64'(kernel[0][0]), 64'd27);
        check("k03", 64'(kernel[0][3]), 64'd83);
        check("k30", 64'(kernel[3][0]), 64'd83);

        // Illegal sigma: immediate done, err set, previous kernel kept.
        run_req(3'd0, 1'b1, e_err, 1'b1, 1'b0);
        wait_done(20);
        repeat (4) @(negedge clk);
        check("err_held", {63'd0, err}, 64'd1);

        // Next valid start clears err and rebuilds from zero.
        run_req(3'd1, 1'b1, e_1d_s1, 1'b1, 1'b1);
        check("err_cleared", {63'd0, err}, 64'd0);
        wait_done(100);

        run_req(3'd7, 1'b1, e_1d_s7, 1'b1, 1'b1);
        wait_done(100);

        // Disturbed 2D run: extra start pulses and sigma/mode changes mid-EXPAND are ignored.
        run_req(3'd2, 1'b0, e_2d_s2, 1'b1, 1'b1);
        repeat (25) @(negedge clk);
        sigma = 3'd5;
        mode  = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sigma = 3'd3;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(200);

        // Reset in the middle of EXPAND drops the partial kernel.
        run_req(3'd2, 1'b0, e_2d_s2, 1'b0, 1'b1);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        check("midrst_err", {63'd0, err}, 64'd0);
        check("midrst_sum", 64'(sum), 64'd0);
        check_kernel("midrst_kernel", kernel, '0);
        rst = 1'b0;

        // Fresh start after the reset completes normally.
        run_req(3'd2, 1'b1, e_1d_s2, 1'b1, 1'b1);
        wait_done(100);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
